rd_serial_tx: RTL and testbench

Upstream feeder for the radio-detector receive interface: takes 12-bit sample pairs over a valid/ready handshake and serializes them onto two data lines plus a transfer-enable. The receive interface deserializes and writes these frames into its memory buffers. The block is used as the on-board RD stream source for loopback and self-test, and as the bench driver for the receive side.

---
 rtl/rd_serial_tx.sv | 197 +++++++++++++++++++
 tb/tb_rd_serial_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_serial_tx.sv
// rd_serial_tx: serializes 12-bit sample pairs onto two frame-aligned data
// lines with a transfer-enable, 13-cycle frames (12 data bits MSB first plus
// a trailer bit). Optional build macro RD_TX_PARITY_EN: when defined the
// trailer is odd parity over the line's 12 data bits, otherwise a constant
// 1 stop bit.
module rd_serial_tx #(
  parameter int unsigned FRAMES_PER_XFR = 1024
) (
  input  logic        SERIAL_CLK_IN,
  input  logic        RST,
  input  logic        START_IN,
  input  logic        STOP_IN,
  input  logic [11:0] SAMPLE0_IN,
  input  logic [11:0] SAMPLE1_IN,
  input  logic        SAMPLE_VALID,
  output logic        SAMPLE_READY,
  output logic        SERIAL_DATA0_OUT,
  output logic        SERIAL_DATA1_OUT,
  output logic        ENABLE_XFR_OUT,
  output logic [31:0] STATUS
);

  localparam int unsigned SW  = 12;
  localparam int unsigned BCW = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW1 = CW + 1;

  localparam logic [BCW-1:0] LAST_DATA_BIT = BCW'(SW - 1);
  localparam logic [BCW-1:0] TRAILER_BIT   = BCW'(SW);
  localparam logic [CW1-1:0] FRAMES_LIM    = CW1'(FRAMES_PER_XFR);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]  sh0_q, sh0_d;
  logic [SW-1:0]  sh1_q, sh1_d;
  logic           data0_q, data0_d;
  logic           data1_q, data1_d;
  logic           en_q, en_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           underrun_q, underrun_d;
  logic           stopped_q, stopped_d;
  logic           stop_lat_q, stop_lat_d;
`ifdef RD_TX_PARITY_EN
  logic           par0_q, par0_d;
  logic           par1_q, par1_d;
`endif

  logic           trailer0, trailer1;
  logic           load;
  logic           more;
  logic [CW1-1:0] cnt_next;
  logic [SW-1:0]  ld0, ld1;

  // Trailer bit sent at bit_cnt 12
`ifdef RD_TX_PARITY_EN
  assign trailer0 = par0_q;
  assign trailer1 = par1_q;
`else
  assign trailer0 = 1'b1;
  assign trailer1 = 1'b1;
`endif

  // Next-state, frame sequencing and sample handshake
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    en_d       = en_q;
    cnt_d      = cnt_q;
    underrun_d = underrun_q;
    stopped_d  = stopped_q;
    stop_lat_d = stop_lat_q;
`ifdef RD_TX_PARITY_EN
    par0_d     = par0_q;
    par1_d     = par1_q;
`endif
    SAMPLE_READY = 1'b0;
    load         = 1'b0;
    more         = 1'b0;
    cnt_next     = {1'b0, cnt_q} + CW1'(1);
    // A missing sample is replaced by all ones (underrun frame)
    ld0 = SAMPLE_VALID ? SAMPLE0_IN : '1;
    ld1 = SAMPLE_VALID ? SAMPLE1_IN : '1;

    case (state_q)
      IDLE: begin
        SAMPLE_READY = START_IN;
        if (START_IN) begin
          cnt_d      = '0;
          underrun_d = 1'b0;
          stopped_d  = 1'b0;
          stop_lat_d = 1'b0;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        if (STOP_IN) stop_lat_d = 1'b1;
        if (bit_cnt_q == TRAILER_BIT) begin
          // Frame complete: chain the next one or finish the transfer
          cnt_d        = cnt_next[CW-1:0];
          more         = (cnt_next < FRAMES_LIM) && !STOP_IN && !stop_lat_q;
          SAMPLE_READY = more;
          if (more) begin
            load = 1'b1;
          end else begin
            state_d    = IDLE;
            data0_d    = 1'b1;
            data1_d    = 1'b1;
            en_d       = 1'b0;
            stop_lat_d = 1'b0;
            stopped_d  = (STOP_IN || stop_lat_q) && (cnt_next < FRAMES_LIM);
          end
        end else if (bit_cnt_q == LAST_DATA_BIT) begin
          bit_cnt_d = TRAILER_BIT;
          data0_d   = trailer0;
          data1_d   = trailer1;
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
          data0_d   = sh0_q[SW-1];
          data1_d   = sh1_q[SW-1];
          sh0_d     = {sh0_q[SW-2:0], 1'b0};
          sh1_d     = {sh1_q[SW-2:0], 1'b0};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Frame start: bit 0 goes out immediately, the rest is queued
    if (load) begin
      state_d   = SHIFT;
      bit_cnt_d = '0;
      en_d      = 1'b1;
      data0_d   = ld0[SW-1];
      data1_d   = ld1[SW-1];
      sh0_d     = {ld0[SW-2:0], 1'b0};
      sh1_d     = {ld1[SW-2:0], 1'b0};
      if (!SAMPLE_VALID) underrun_d = 1'b1;
`ifdef RD_TX_PARITY_EN
      par0_d    = ~^ld0;
      par1_d    = ~^ld1;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge SERIAL_CLK_IN or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      data0_q    <= 1'b1;
      data1_q    <= 1'b1;
      en_q       <= 1'b0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
      stopped_q  <= 1'b0;
      stop_lat_q <= 1'b0;
`ifdef RD_TX_PARITY_EN
      par0_q     <= 1'b1;
      par1_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      en_q       <= en_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
      stopped_q  <= stopped_d;
      stop_lat_q <= stop_lat_d;
`ifdef RD_TX_PARITY_EN
      par0_q     <= par0_d;
      par1_q     <= par1_d;
`endif
    end
  end

  assign SERIAL_DATA0_OUT = data0_q;
  assign SERIAL_DATA1_OUT = data1_q;
  assign ENABLE_XFR_OUT   = en_q;
  assign STATUS           = {13'd0, stopped_q, underrun_q, (state_q == SHIFT), cnt_q};

endmodule

// File: tb/tb_rd_serial_tx.sv
// Testbench for rd_serial_tx: scoreboard of expected frames, enable run
// lengths and end-of-transfer status, checked by monitors watching the lines.
module tb_rd_serial_tx;

  localparam int unsigned F = 4;

  logic clk;
  logic rst;

  // Instance A: FRAMES_PER_XFR = 4
  logic        start_a, stop_a, sv_a, rdy_a, d0_a, d1_a, en_a;
  logic [11:0] s0_a, s1_a;
  logic [31:0] st_a;
  // Instance B: FRAMES_PER_XFR = 1, continuous start
  logic        start_b, stop_b, sv_b, rdy_b, d0_b, d1_b, en_b;
  logic [11:0] s0_b, s1_b;
  logic [31:0] st_b;

  rd_serial_tx #(.FRAMES_PER_XFR(F)) u_dut_a (
    .SERIAL_CLK_IN(clk), .RST(rst), .START_IN(start_a), .STOP_IN(stop_a),
    .SAMPLE0_IN(s0_a), .SAMPLE1_IN(s1_a), .SAMPLE_VALID(sv_a), .SAMPLE_READY(rdy_a),
    .SERIAL_DATA0_OUT(d0_a), .SERIAL_DATA1_OUT(d1_a), .ENABLE_XFR_OUT(en_a), .STATUS(st_a)
  );

  rd_serial_tx #(.FRAMES_PER_XFR(1)) u_dut_b (
    .SERIAL_CLK_IN(clk), .RST(rst), .START_IN(start_b), .STOP_IN(stop_b),
    .SAMPLE0_IN(s0_b), .SAMPLE1_IN(s1_b), .SAMPLE_VALID(sv_b), .SAMPLE_READY(rdy_b),
    .SERIAL_DATA0_OUT(d0_b), .SERIAL_DATA1_OUT(d1_b), .ENABLE_XFR_OUT(en_b), .STATUS(st_b)
  );

  int n_cmp;
  int n_bad;
  int runs_b;

  logic [25:0] exp_fr_q[$];
  int          exp_run_q[$];
  logic [31:0] exp_st_q[$];
  logic [25:0] exp_b_q[$];

  logic [11:0] s0a[4];
  logic [11:0] s1a[4];
  logic        va[4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected 13-bit frame on one line, first transmitted bit in the MSB
  function automatic logic [12:0] frame_word(input logic [11:0] s);
    logic t;
`ifdef RD_TX_PARITY_EN
    t = (($countones(s) % 2) == 0);
`else
    t = 1'b1;
`endif
    return {s, t};
  endfunction

  // Monitor A: frames, enable run length, status at transfer end
  initial begin : mon_a
    logic [12:0] c0, c1;
    logic [25:0] e;
    logic [31:0] es;
    int nb, run, er;
    logic pen;
    c0 = '0; c1 = '0; nb = 0; run = 0; pen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nb = 0; run = 0; pen = 1'b0;
      end else begin
        if (en_a) begin
          c0 = {c0[11:0], d0_a};
          c1 = {c1[11:0], d1_a};
          nb++; run++;
          if (nb == 13) begin
            nb = 0;
            chk("frame_pending_a", 32'(exp_fr_q.size() > 0), 32'd1);
            if (exp_fr_q.size() > 0) begin
              e = exp_fr_q.pop_front();
              chk("line0_frame", 32'(c0), 32'(e[25:13]));
              chk("line1_frame", 32'(c1), 32'(e[12:0]));
            end
          end
        end else if (pen) begin
          er = (exp_run_q.size() > 0) ? exp_run_q.pop_front() : -1;
          es = (exp_st_q.size() > 0) ? exp_st_q.pop_front() : '1;
          chk("enable_run_a", 32'(run), 32'(er));
          chk("status_end_a", st_a, es);
          chk("partial_frame_a", 32'(nb), 32'd0);
          run = 0;
        end
        pen = en_a;
      end
    end
  end

  // Monitor B: frames, 13-cycle runs, 1-cycle gaps between transfers
  initial begin : mon_b
    logic [12:0] c0, c1;
    logic [25:0] e;
    int nb, run, gap;
    logic pen;
    c0 = '0; c1 = '0; nb = 0; run = 0; gap = 0; pen = 1'b0; runs_b = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nb = 0; run = 0; pen = 1'b0;
      end else begin
        if (en_b) begin
          if (!pen && runs_b > 0) chk("gap_b", 32'(gap), 32'd1);
          c0 = {c0[11:0], d0_b};
          c1 = {c1[11:0], d1_b};
          nb++; run++;
          if (nb == 13) begin
            nb = 0;
            chk("frame_pending_b", 32'(exp_b_q.size() > 0), 32'd1);
            if (exp_b_q.size() > 0) begin
              e = exp_b_q.pop_front();
              chk("line0_frame_b", 32'(c0), 32'(e[25:13]));
              chk("line1_frame_b", 32'(c1), 32'(e[12:0]));
            end
          end
        end else if (pen) begin
          chk("enable_run_b", 32'(run), 32'd13);
          chk("status_end_b", st_b, 32'h0000_0001);
          runs_b++;
          run = 0;
          gap = 1;
        end else begin
          gap++;
        end
        pen = en_b;
      end
    end
  end

  // One transfer on instance A; sf/sb = frame/bit at which STOP_IN pulses (sf<0: none)
  task automatic run_xfr(input int sf, input int sb);
    int nfr, idx;
    logic stopped, und, exp_rdy;
    nfr = F; stopped = 1'b0; und = 1'b0;
    if (sf >= 0 && sf < int'(F)) begin
      nfr = sf + 1;
      stopped = (nfr < int'(F));
    end
    for (int k = 0; k < nfr; k++) begin
      logic [11:0] a, b;
      a = va[k] ? s0a[k] : 12'hFFF;
      b = va[k] ? s1a[k] : 12'hFFF;
      if (!va[k]) und = 1'b1;
      exp_fr_q.push_back({frame_word(a), frame_word(b)});
    end
    exp_run_q.push_back(13 * nfr);
    exp_st_q.push_back({13'd0, stopped, und, 1'b0, 16'(nfr)});

    @(negedge clk);
    start_a = 1'b1;
    idx = 0;
    sv_a = va[0]; s0_a = s0a[0]; s1_a = s1a[0];
    #1 chk("start_ready", 32'(rdy_a), 32'd1);
    @(posedge clk);
    idx = 1;
    for (int cyc = 0; cyc < 13 * nfr; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      stop_a  = (cyc == 13 * sf + sb);
      if (idx < 4) begin
        sv_a = va[idx]; s0_a = s0a[idx]; s1_a = s1a[idx];
      end else begin
        sv_a = 1'b0;
      end
      #1;
      exp_rdy = ((cyc % 13) == 12) && ((cyc / 13) + 1 < nfr);
      chk("ready_a", 32'(rdy_a), 32'(exp_rdy));
      if (cyc == 0) chk("start_flags", 32'(st_a[18:16]), 32'({1'b0, !va[0], 1'b1}));
      @(posedge clk);
      if (exp_rdy) idx++;
    end
    @(negedge clk);
    stop_a = 1'b0; start_a = 1'b0; sv_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_samples();
    for (int k = 0; k < 4; k++) begin
      s0a[k] = 12'($urandom);
      s1a[k] = 12'($urandom);
      va[k]  = 1'b1;
    end
  endtask

  task automatic run_b();
    logic [23:0] pend[$];
    int pulses;
    for (int i = 0; i < 6; i++) begin
      logic [23:0] p;
      p = 24'($urandom);
      pend.push_back(p);
      exp_b_q.push_back({frame_word(p[23:12]), frame_word(p[11:0])});
    end
    @(negedge clk);
    start_b = 1'b1; sv_b = 1'b1; pulses = 0;
    for (int cyc = 0; cyc < 200 && pulses < 6; cyc++) begin
      s0_b = pend[0][23:12];
      s1_b = pend[0][11:0];
      #1 chk("ready_b", 32'(rdy_b), 32'((cyc % 14) == 0));
      if (rdy_b) begin
        pulses++;
        void'(pend.pop_front());
      end
      @(negedge clk);
    end
    start_b = 1'b0; sv_b = 1'b0;
    chk("starts_b", 32'(pulses), 32'd6);
    repeat (20) @(negedge clk);
    chk("runs_b", 32'(runs_b), 32'd6);
  endtask

  initial begin : stim
    int sf, sb;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    start_a = 1'b0; stop_a = 1'b0; sv_a = 1'b0; s0_a = '0; s1_a = '0;
    start_b = 1'b0; stop_b = 1'b0; sv_b = 1'b0; s0_b = '0; s1_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_lines", 32'({d0_a, d1_a, en_a}), 32'b110);
    chk("rst_status", st_a, 32'd0);
    start_a = 1'b1;
    #1 chk("rst_ready_follows_start", 32'(rdy_a), 32'd1);
    start_a = 1'b0;
    #1 chk("rst_ready_low", 32'(rdy_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_lines", 32'({d0_a, d1_a, en_a}), 32'b110);
      chk("idle_status", st_a, 32'd0);
    end

    // Directed: two known pairs then random, full transfer
    rand_samples();
    s0a[0] = 12'hAAA; s1a[0] = 12'h555;
    s0a[1] = 12'h001; s1a[1] = 12'hFFE;
    run_xfr(-1, 0);
    // Underrun at second frame start
    va[1] = 1'b0;
    run_xfr(-1, 0);
    // Early stop mid-frame 1, stop on last trailer, stop on first trailer, stop at bit 0
    rand_samples();
    run_xfr(1, 5);
    run_xfr(3, 12);
    run_xfr(0, 12);
    run_xfr(0, 0);

    // Reset at bit 7 of frame 0, then a clean transfer
    @(negedge clk);
    start_a = 1'b1; sv_a = 1'b1; s0_a = 12'($urandom); s1_a = 12'($urandom);
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_lines", 32'({d0_a, d1_a, en_a}), 32'b110);
    chk("midrst_status", st_a, 32'd0);
    #4 rst = 1'b0;
    sv_a = 1'b0;
    rand_samples();
    run_xfr(-1, 0);

    // Randomized transfers
    for (int r = 0; r < 10; r++) begin
      rand_samples();
      for (int k = 0; k < 4; k++) va[k] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        sf = int'($urandom_range(0, 3));
        sb = int'($urandom_range(0, 12));
      end else begin
        sf = -1; sb = 0;
      end
      run_xfr(sf, sb);
    end

    run_b();

    repeat (5) @(negedge clk);
    chk("leftover_frames_a", 32'(exp_fr_q.size()), 32'd0);
    chk("leftover_runs_a", 32'(exp_run_q.size()), 32'd0);
    chk("leftover_status_a", 32'(exp_st_q.size()), 32'd0);
    chk("leftover_frames_b", 32'(exp_b_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
